// File: rtl/uart_line_sender.sv
// uart_line_sender: buffers a CR-terminated command line and streams it into a uart
// transmit handshake, optionally checking each byte's echo on the receive side.
module uart_line_sender #(
    parameter int DEPTH        = 16,
    parameter int ECHO_TIMEOUT = 50000,
    parameter bit CHECK_ECHO   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(ECHO_TIMEOUT + 1);
    localparam logic [7:0] CR = 8'h0D;

    typedef enum logic [1:0] {LOAD, SEND, ECHO, DONE} state_t;

    state_t        state, state_n;
    logic [7:0]    line_buf [DEPTH];
    logic [PW-1:0] count, count_n, idx, idx_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [1:0]    err_n;
    logic [7:0]    cur;

    assign cur       = line_buf[idx[PW-2:0]];
    assign cmd_ready = state == LOAD;
    assign rx_ready  = state == LOAD || state == ECHO;
    assign tx_valid  = state == SEND;
    assign tx_data   = cur;
    assign busy      = state != LOAD;
    assign done      = state == DONE;
    assign error     = err_code != 2'b00;

    always_ff @(posedge clk)
        if (state == LOAD && cmd_valid)
            line_buf[count[PW-2:0]] <= cmd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            count    <= '0;
            idx      <= '0;
            tcnt     <= '0;
            err_code <= 2'b00;
        end else begin
            state    <= state_n;
            count    <= count_n;
            idx      <= idx_n;
            tcnt     <= tcnt_n;
            err_code <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = idx;
        tcnt_n  = tcnt;
        err_n   = err_code;
        case (state)
            LOAD: if (cmd_valid) begin
                err_n   = 2'b00;
                count_n = count + 1'b1;
                if (cmd_data == CR) begin
                    state_n = SEND;
                    idx_n   = '0;
                end else if (count_n == PW'(DEPTH)) begin
                    err_n   = 2'b11;
                    count_n = '0;
                end
            end
            SEND: if (tx_ready) begin
                if (cur == CR)
                    state_n = DONE;
                else if (CHECK_ECHO) begin
                    state_n = ECHO;
                    tcnt_n  = '0;
                end else
                    idx_n = idx + 1'b1;
            end
            // an arriving echo wins over a timeout on the same edge
            ECHO: if (rx_valid) begin
                if (rx_data == cur) begin
                    idx_n   = idx + 1'b1;
                    state_n = SEND;
                end else begin
                    err_n   = 2'b01;
                    count_n = '0;
                    idx_n   = '0;
                    state_n = LOAD;
                end
            end else if (tcnt == TW'(ECHO_TIMEOUT - 1)) begin
                err_n   = 2'b10;
                count_n = '0;
                idx_n   = '0;
                state_n = LOAD;
            end else
                tcnt_n = tcnt + 1'b1;
            DONE: begin
                count_n = '0;
                idx_n   = '0;
                state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end
endmodule
